// File: rtl/cell_test_sequencer_if.sv
// Stimulus/response and start/busy/done bundle for cell_test_sequencer.
// exhaustive_i exists only when CELL_SEQ_EXHAUSTIVE_EN is defined.
interface cell_test_sequencer_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 2,
    parameter int SIG_W = 16,
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             abort_i;
    logic [15:0]      seed_i;
    logic [CNT_W-1:0] count_i;
    logic [OUT_W-1:0] resp_i;
`ifdef CELL_SEQ_EXHAUSTIVE_EN
    logic             exhaustive_i;
`endif
    logic [IN_W-1:0]  stim_o;
    logic             busy_o;
    logic             done_o;
    logic [SIG_W-1:0] signature_o;
    logic [CNT_W-1:0] vec_idx_o;

    modport master (
`ifdef CELL_SEQ_EXHAUSTIVE_EN
        output exhaustive_i,
`endif
        output start_i, abort_i, seed_i, count_i, resp_i,
        input  stim_o, busy_o, done_o, signature_o, vec_idx_o
    );

    modport slave (
`ifdef CELL_SEQ_EXHAUSTIVE_EN
        input  exhaustive_i,
`endif
        input  start_i, abort_i, seed_i, count_i, resp_i,
        output stim_o, busy_o, done_o, signature_o, vec_idx_o
    );
endinterface

// File: rtl/cell_test_sequencer.sv
// Pseudo-random cell stimulus with settle wait and MISR response compaction.
// Defining CELL_SEQ_EXHAUSTIVE_EN adds a binary-count stimulus mode.
//
// state     | meaning
// S_IDLE    | waiting for start, stim parked
// S_SETTLE  | stim applied, settle counter running down
// S_CAPTURE | resp folded into MISR, advance to next vector
// S_DONE    | signature and vec_idx valid, waiting for start
module cell_test_sequencer #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 2,
    parameter int SIG_W      = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cell_test_sequencer_if.slave bus
);
    localparam int          SET_W    = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [15:0] SEED_SUB = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      pat_q, pat_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] vec_idx_q, vec_idx_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] vec_inc;
    logic [OUT_W-1:0] resp;
    logic [15:0]      first_pat, next_pat;
    logic             start_ok, last_vec, busy, done;
`ifdef CELL_SEQ_EXHAUSTIVE_EN
    logic             exh_q, exh_d;
`endif

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign resp     = bus.resp_i;
    assign vec_inc  = vec_idx_q + CNT_W'(1);
    assign last_vec = (vec_inc == count_q);
    assign start_ok = bus.start_i && !bus.abort_i &&
                      (state_q == S_IDLE || state_q == S_DONE);

    always_comb begin
        first_pat = (bus.seed_i == 16'd0) ? SEED_SUB : bus.seed_i;
        next_pat  = lfsr_next(pat_q);
`ifdef CELL_SEQ_EXHAUSTIVE_EN
        if (bus.exhaustive_i) first_pat = 16'd0;
        if (exh_q)            next_pat  = pat_q + 16'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (bus.start_i)
                    state_d = (bus.count_i == '0) ? S_DONE : S_SETTLE;
                S_SETTLE:  if (settle_q == '0) state_d = S_CAPTURE;
                S_CAPTURE: state_d = last_vec ? S_DONE : S_SETTLE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        pat_d     = pat_q;
        sig_d     = sig_q;
        vec_idx_d = vec_idx_q;
        count_d   = count_q;
        settle_d  = settle_q;
`ifdef CELL_SEQ_EXHAUSTIVE_EN
        exh_d     = exh_q;
`endif
        if (bus.abort_i) begin
            pat_d = 16'd0;
        end else if (start_ok) begin
            sig_d     = '0;
            vec_idx_d = '0;
            count_d   = bus.count_i;
            settle_d  = SET_W'(SETTLE_CYC);
`ifdef CELL_SEQ_EXHAUSTIVE_EN
            exh_d     = bus.exhaustive_i;
`endif
            // A zero-length run goes straight to DONE and leaves the pins alone.
            if (bus.count_i != '0) pat_d = first_pat;
        end else if (state_q == S_SETTLE) begin
            if (settle_q != '0) settle_d = settle_q - SET_W'(1);
        end else if (state_q == S_CAPTURE) begin
            sig_d     = {sig_q[14:0], sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10]}
                        ^ SIG_W'(resp);
            vec_idx_d = vec_inc;
            if (!last_vec) begin
                pat_d    = next_pat;
                settle_d = SET_W'(SETTLE_CYC);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= 16'd0;
            sig_q     <= '0;
            vec_idx_q <= '0;
            count_q   <= '0;
            settle_q  <= '0;
`ifdef CELL_SEQ_EXHAUSTIVE_EN
            exh_q     <= 1'b0;
`endif
        end else begin
            pat_q     <= pat_d;
            sig_q     <= sig_d;
            vec_idx_q <= vec_idx_d;
            count_q   <= count_d;
            settle_q  <= settle_d;
`ifdef CELL_SEQ_EXHAUSTIVE_EN
            exh_q     <= exh_d;
`endif
        end
    end

    assign bus.stim_o      = pat_q[IN_W-1:0];
    assign bus.busy_o      = busy;
    assign bus.done_o      = done;
    assign bus.signature_o = sig_q;
    assign bus.vec_idx_o   = vec_idx_q;
endmodule

// File: tb/tb_cell_test_sequencer.sv
// Randomized self-checking bench for cell_test_sequencer against a vector-list model.
module tb_cell_test_sequencer;
    localparam int S       = 2;
    localparam int PER_VEC = S + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loopback = 1'b0;
    logic [1:0]  resp_tab    [256];
    logic [15:0] exp_stim    [256];
    logic [15:0] exp_sig_aft [257];
    int checks = 0;
    int errors = 0;

    cell_test_sequencer_if bus_if ();
    cell_test_sequencer #(.SETTLE_CYC(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

    always #5 clk = ~clk;
    assign bus_if.resp_i = loopback ? bus_if.stim_o[1:0] : resp_tab[bus_if.vec_idx_o[7:0]];

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    function automatic logic [15:0] ref_misr(input logic [15:0] sg, input logic [1:0] r);
        return {sg[14:0], sg[15] ^ sg[13] ^ sg[12] ^ sg[10]} ^ {14'd0, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_resp();
        for (int k = 0; k < 256; k++) resp_tab[k] = 2'($urandom_range(0, 3));
    endtask

    // Expected stim per vector and signature after each vector.
    task automatic build_model(input logic [15:0] seed, input int n);
        logic [15:0] p, sg;
        logic [1:0]  r;
        p  = (seed == 16'd0) ? 16'hACE1 : seed;
        sg = 16'd0;
        exp_sig_aft[0] = 16'd0;
        for (int k = 0; k < n; k++) begin
            exp_stim[k] = p;
            r  = loopback ? p[1:0] : resp_tab[k];
            sg = ref_misr(sg, r);
            exp_sig_aft[k+1] = sg;
            p = ref_step(p);
        end
    endtask

    task automatic start_run(input logic [15:0] seed, input int n);
        bus_if.seed_i  = seed;
        bus_if.count_i = 16'(n);
        bus_if.start_i = 1'b1;
        step();
        bus_if.start_i = 1'b0;
    endtask

    task automatic run_to_done(input int n, output int edges, output int busy_cyc, output bit stim_ok);
        edges = 0; busy_cyc = 0; stim_ok = 1'b1;
        while (!bus_if.done_o && edges < n * PER_VEC + 20) begin
            if (bus_if.busy_o) begin
                busy_cyc++;
                if (bus_if.stim_o !== exp_stim[bus_if.vec_idx_o[7:0]]) stim_ok = 1'b0;
            end
            step();
            edges++;
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++; if (bus_if.stim_o !== 16'd0) begin errors++; $display("FAIL reset_stim got %h want 0000", bus_if.stim_o); end
        checks++; if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%b done=%b want 0/0", bus_if.busy_o, bus_if.done_o); end
        checks++; if (bus_if.signature_o !== 16'd0 || bus_if.vec_idx_o !== 16'd0) begin errors++; $display("FAIL reset_sig got sig=%h idx=%0d want 0/0", bus_if.signature_o, bus_if.vec_idx_o); end
        rst_n = 1'b1;
        step();
        checks++; if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy=%b done=%b", bus_if.busy_o, bus_if.done_o); end
    endtask

    task automatic test_loopback_single();
        int e, b; bit ok;
        loopback = 1'b1;
        build_model(16'h0003, 1);
        start_run(16'h0003, 1);
        run_to_done(1, e, b, ok);
        checks++; if (e !== 4) begin errors++; $display("FAIL lb_latency got %0d edges want 4", e); end
        checks++; if (b !== 4) begin errors++; $display("FAIL lb_busy got %0d cycles want 4", b); end
        checks++; if (bus_if.signature_o !== 16'h0003) begin errors++; $display("FAIL lb_sig got %h want 0003", bus_if.signature_o); end
        checks++; if (bus_if.vec_idx_o !== 16'd1) begin errors++; $display("FAIL lb_idx got %0d want 1", bus_if.vec_idx_o); end
        checks++; if (!ok) begin errors++; $display("FAIL lb_stim got bad stim want 0003"); end
        loopback = 1'b0;
    endtask

    task automatic test_zero_seed();
        int e, b, g; bit ok;
        randomize_resp();
        build_model(16'h0000, 2);
        start_run(16'h0000, 2);
        checks++; if (bus_if.stim_o !== 16'hACE1) begin errors++; $display("FAIL zs_first got %h want ace1", bus_if.stim_o); end
        g = 0;
        while (bus_if.vec_idx_o !== 16'd1 && g < 20) begin step(); g++; end
        checks++; if (bus_if.stim_o !== 16'h59C3) begin errors++; $display("FAIL zs_second got %h want 59c3", bus_if.stim_o); end
        run_to_done(2, e, b, ok);
        checks++; if (bus_if.done_o !== 1'b1 || bus_if.signature_o !== exp_sig_aft[2]) begin errors++; $display("FAIL zs_sig got done=%b sig=%h want 1/%h", bus_if.done_o, bus_if.signature_o, exp_sig_aft[2]); end
    endtask

    task automatic test_random_runs();
        int e, b, n; bit ok; logic [15:0] sd;
        for (int r = 0; r < 6; r++) begin
            sd = 16'($urandom);
            n  = $urandom_range(1, 30);
            randomize_resp();
            build_model(sd, n);
            start_run(sd, n);
            run_to_done(n, e, b, ok);
            checks++; if (e !== n * PER_VEC) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", r, e, n * PER_VEC); end
            checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_stim got wrong stim sequence seed=%h want model", r, sd); end
            checks++; if (bus_if.signature_o !== exp_sig_aft[n]) begin errors++; $display("FAIL rnd%0d_sig got %h want %h", r, bus_if.signature_o, exp_sig_aft[n]); end
            checks++; if (bus_if.vec_idx_o !== 16'(n)) begin errors++; $display("FAIL rnd%0d_idx got %0d want %0d", r, bus_if.vec_idx_o, n); end
        end
    endtask

    task automatic test_count_zero_and_busy_start();
        int e, b; bit ok; logic [15:0] prev, sd;
        prev = bus_if.stim_o;
        start_run(16'($urandom), 0);
        checks++; if (bus_if.done_o !== 1'b1 || bus_if.busy_o !== 1'b0) begin errors++; $display("FAIL cz_done got done=%b busy=%b want 1/0", bus_if.done_o, bus_if.busy_o); end
        checks++; if (bus_if.signature_o !== 16'd0 || bus_if.vec_idx_o !== 16'd0) begin errors++; $display("FAIL cz_sig got sig=%h idx=%0d want 0/0", bus_if.signature_o, bus_if.vec_idx_o); end
        checks++; if (bus_if.stim_o !== prev) begin errors++; $display("FAIL cz_stim got %h want %h", bus_if.stim_o, prev); end
        sd = 16'($urandom);
        randomize_resp();
        build_model(sd, 3);
        start_run(sd, 3);
        step(); step();
        bus_if.seed_i = ~sd; bus_if.count_i = 16'd7; bus_if.start_i = 1'b1;
        step();
        bus_if.start_i = 1'b0;
        run_to_done(3, e, b, ok);
        checks++; if (e + 3 !== 3 * PER_VEC) begin errors++; $display("FAIL bs_latency got %0d want %0d", e + 3, 3 * PER_VEC); end
        checks++; if (bus_if.vec_idx_o !== 16'd3) begin errors++; $display("FAIL bs_idx got %0d want 3", bus_if.vec_idx_o); end
        checks++; if (bus_if.signature_o !== exp_sig_aft[3] || !ok) begin errors++; $display("FAIL bs_sig got %h stim_ok=%b want %h", bus_if.signature_o, ok, exp_sig_aft[3]); end
    endtask

    task automatic test_abort();
        int g; logic [15:0] sd;
        sd = 16'($urandom);
        randomize_resp();
        build_model(sd, 100);
        start_run(sd, 100);
        g = 0;
        while (bus_if.vec_idx_o !== 16'd10 && g < 200) begin step(); g++; end
        bus_if.abort_i = 1'b1;
        step();
        bus_if.abort_i = 1'b0;
        checks++; if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0) begin errors++; $display("FAIL ab_flags got busy=%b done=%b want 0/0", bus_if.busy_o, bus_if.done_o); end
        checks++; if (bus_if.vec_idx_o !== 16'd10) begin errors++; $display("FAIL ab_idx got %0d want 10", bus_if.vec_idx_o); end
        checks++; if (bus_if.stim_o !== 16'd0) begin errors++; $display("FAIL ab_stim got %h want 0000", bus_if.stim_o); end
        checks++; if (bus_if.signature_o !== exp_sig_aft[10]) begin errors++; $display("FAIL ab_sig got %h want %h", bus_if.signature_o, exp_sig_aft[10]); end
        bus_if.abort_i = 1'b1; bus_if.start_i = 1'b1; bus_if.count_i = 16'd5; bus_if.seed_i = 16'h1234;
        step();
        bus_if.abort_i = 1'b0; bus_if.start_i = 1'b0;
        step();
        checks++; if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0 || bus_if.vec_idx_o !== 16'd10) begin errors++; $display("FAIL ab_start got busy=%b done=%b idx=%0d want 0/0/10", bus_if.busy_o, bus_if.done_o, bus_if.vec_idx_o); end
    endtask

    task automatic test_reset_mid_run();
        randomize_resp();
        start_run(16'($urandom), 10);
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        checks++; if (bus_if.stim_o !== 16'd0 || bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0) begin errors++; $display("FAIL rm_state got stim=%h busy=%b done=%b want 0", bus_if.stim_o, bus_if.busy_o, bus_if.done_o); end
        checks++; if (bus_if.signature_o !== 16'd0 || bus_if.vec_idx_o !== 16'd0) begin errors++; $display("FAIL rm_sig got sig=%h idx=%0d want 0/0", bus_if.signature_o, bus_if.vec_idx_o); end
        step();
        rst_n = 1'b1;
        step(); step();
        checks++; if (bus_if.busy_o !== 1'b0 || bus_if.vec_idx_o !== 16'd0) begin errors++; $display("FAIL rm_resume got busy=%b idx=%0d want 0/0", bus_if.busy_o, bus_if.vec_idx_o); end
    endtask

`ifdef CELL_SEQ_EXHAUSTIVE_EN
    task automatic test_exhaustive();
        int e, b; bit ok;
        loopback = 1'b1;
        for (int k = 0; k < 4; k++) exp_stim[k] = 16'(k);
        bus_if.exhaustive_i = 1'b1;
        start_run(16'($urandom), 4);
        bus_if.exhaustive_i = 1'b0;
        run_to_done(4, e, b, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ex_stim got non-binary sequence want 0,1,2,3"); end
        checks++; if (bus_if.signature_o !== 16'h0003) begin errors++; $display("FAIL ex_sig got %h want 0003", bus_if.signature_o); end
        checks++; if (e !== 4 * PER_VEC) begin errors++; $display("FAIL ex_latency got %0d want %0d", e, 4 * PER_VEC); end
        loopback = 1'b0;
    endtask
`endif

    initial begin
        bus_if.start_i = 1'b0;
        bus_if.abort_i = 1'b0;
        bus_if.seed_i  = 16'd0;
        bus_if.count_i = 16'd0;
`ifdef CELL_SEQ_EXHAUSTIVE_EN
        bus_if.exhaustive_i = 1'b0;
`endif
        randomize_resp();
        test_reset();
        test_loopback_single();
        test_zero_seed();
        test_random_runs();
        test_count_zero_and_busy_start();
        test_abort();
        test_reset_mid_run();
`ifdef CELL_SEQ_EXHAUSTIVE_EN
        test_exhaustive();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
